mem_stage: RTL

Memory-access stage of the RV64 pipeline, directly downstream of `execute`. It consumes the `MEM_*` latch and performs loads and stores over a level-handshake data-memory port. Load data is aligned and extended here, and the stage asserts `V_MEM_STALL` back to `execute` while an access is outstanding. It registers the `WB_*` latch consumed by writeback.

---
 rtl/mem_stage.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: turns MEM_* loads/stores into level-handshake data-memory
// requests, aligns/extends load data, and registers the WB_* latch.
module mem_stage (
    input  logic        clk,
    input  logic        RESET,
    input  logic        MEM_V,
    input  logic [31:0] MEM_IR,
    input  logic [63:0] MEM_NPC,
    input  logic [63:0] MEM_ALU_RESULT,
    input  logic [63:0] MEM_SR2,
    input  logic [63:0] MEM_SR1,
    input  logic [63:0] MEM_RFD,
    input  logic [63:0] MEM_CSRFD,
    input  logic        MEM_ECALL,
    output logic        V_MEM_STALL,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [63:0] DMEM_ADDR,
    output logic [63:0] DMEM_WDATA,
    output logic [7:0]  DMEM_WSTRB,
    input  logic [63:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        WB_V,
    output logic [31:0] WB_IR,
    output logic [63:0] WB_NPC,
    output logic [63:0] WB_DATA,
    output logic [63:0] WB_RFD,
    output logic [63:0] WB_CSRFD,
    output logic        WB_ECALL,
    output logic        WB_FAULT
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic [2:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;

    logic        wb_v_q, wb_v_d;
    logic [31:0] wb_ir_q, wb_ir_d;
    logic [63:0] wb_npc_q, wb_npc_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [63:0] wb_rfd_q, wb_rfd_d;
    logic [63:0] wb_csrfd_q, wb_csrfd_d;
    logic        wb_ecall_q, wb_ecall_d;
    logic        wb_fault_q, wb_fault_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [2:0]  off;
    logic        is_load, is_store, is_link, good_f3, aligned;
    logic        mem_go, mem_fault;
    logic [7:0]  strobe_base;
    logic [63:0] rdata_shifted, load_data;
    logic        unused_sr1;

    assign opcode     = MEM_IR[6:0];
    assign funct3     = MEM_IR[14:12];
    assign off        = MEM_ALU_RESULT[2:0];
    assign unused_sr1 = ^MEM_SR1;

    always_comb begin
        is_load     = (opcode == OP_LOAD);
        is_store    = (opcode == OP_STORE);
        is_link     = (opcode == OP_JAL) || (opcode == OP_JALR);
        good_f3     = (is_load && (funct3 != 3'd7)) || (is_store && !funct3[2]);
        aligned     = 1'b1;
        strobe_base = 8'h01;
        case (funct3[1:0])
            2'd0: begin aligned = 1'b1;            strobe_base = 8'h01; end
            2'd1: begin aligned = !off[0];         strobe_base = 8'h03; end
            2'd2: begin aligned = (off[1:0] == 2'd0); strobe_base = 8'h0F; end
            default: begin aligned = (off == 3'd0); strobe_base = 8'hFF; end
        endcase
        mem_go    = MEM_V && good_f3 && aligned;
        mem_fault = MEM_V && (is_load || is_store) && !(good_f3 && aligned);
    end

    // Load data uses the offset/funct3 captured at issue, not the live inputs.
    always_comb begin
        rdata_shifted = DMEM_RDATA >> {off_q, 3'b000};
        case (funct3_q)
            3'd0:    load_data = {{56{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'd1:    load_data = {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'd2:    load_data = {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            3'd4:    load_data = {56'd0, rdata_shifted[7:0]};
            3'd5:    load_data = {48'd0, rdata_shifted[15:0]};
            3'd6:    load_data = {32'd0, rdata_shifted[31:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        we_d       = we_q;
        off_d      = off_q;
        funct3_d   = funct3_q;
        wb_v_d     = 1'b0;
        wb_ir_d    = 32'd0;
        wb_npc_d   = 64'd0;
        wb_data_d  = 64'd0;
        wb_rfd_d   = 64'd0;
        wb_csrfd_d = 64'd0;
        wb_ecall_d = 1'b0;
        wb_fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_go) begin
                    state_d  = ACCESS;
                    addr_d   = {MEM_ALU_RESULT[63:3], 3'b000};
                    we_d     = is_store;
                    wstrb_d  = is_store ? (strobe_base << off) : 8'h00;
                    wdata_d  = is_store ? (MEM_SR2 << {off, 3'b000}) : 64'd0;
                    off_d    = off;
                    funct3_d = funct3;
                end else if (MEM_V) begin
                    wb_v_d     = 1'b1;
                    wb_ir_d    = MEM_IR;
                    wb_npc_d   = MEM_NPC;
                    wb_rfd_d   = MEM_RFD;
                    wb_csrfd_d = MEM_CSRFD;
                    wb_ecall_d = MEM_ECALL;
                    wb_fault_d = mem_fault;
                    wb_data_d  = is_link ? MEM_NPC : MEM_ALU_RESULT;
                end
            end
            default: begin
                // execute holds MEM_* stable through the access, so pass-throughs read live inputs
                if (DMEM_ACK) begin
                    state_d    = IDLE;
                    wb_v_d     = 1'b1;
                    wb_ir_d    = MEM_IR;
                    wb_npc_d   = MEM_NPC;
                    wb_rfd_d   = MEM_RFD;
                    wb_csrfd_d = MEM_CSRFD;
                    wb_ecall_d = MEM_ECALL;
                    wb_data_d  = we_q ? MEM_ALU_RESULT : load_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= IDLE;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            wstrb_q    <= 8'd0;
            we_q       <= 1'b0;
            off_q      <= 3'd0;
            funct3_q   <= 3'd0;
            wb_v_q     <= 1'b0;
            wb_ir_q    <= 32'd0;
            wb_npc_q   <= 64'd0;
            wb_data_q  <= 64'd0;
            wb_rfd_q   <= 64'd0;
            wb_csrfd_q <= 64'd0;
            wb_ecall_q <= 1'b0;
            wb_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            we_q       <= we_d;
            off_q      <= off_d;
            funct3_q   <= funct3_d;
            wb_v_q     <= wb_v_d;
            wb_ir_q    <= wb_ir_d;
            wb_npc_q   <= wb_npc_d;
            wb_data_q  <= wb_data_d;
            wb_rfd_q   <= wb_rfd_d;
            wb_csrfd_q <= wb_csrfd_d;
            wb_ecall_q <= wb_ecall_d;
            wb_fault_q <= wb_fault_d;
        end
    end

    assign V_MEM_STALL = ((state_q == IDLE) && mem_go) || ((state_q == ACCESS) && !DMEM_ACK);
    assign DMEM_REQ    = (state_q == ACCESS);
    assign DMEM_WE     = we_q;
    assign DMEM_ADDR   = addr_q;
    assign DMEM_WDATA  = wdata_q;
    assign DMEM_WSTRB  = wstrb_q;
    assign WB_V        = wb_v_q;
    assign WB_IR       = wb_ir_q;
    assign WB_NPC      = wb_npc_q;
    assign WB_DATA     = wb_data_q;
    assign WB_RFD      = wb_rfd_q;
    assign WB_CSRFD    = wb_csrfd_q;
    assign WB_ECALL    = wb_ecall_q;
    assign WB_FAULT    = wb_fault_q;

endmodule
